// File: rtl/icache_line_fetch_if.sv
// Fetch-side and memory line-port signals of the instruction cache.
// master = cache view (initiator toward memory), slave = CPU/memory environment view.
interface icache_line_fetch_if;
  logic         cpu_req;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_data;
  logic         cpu_stall;
  logic         inv;
  logic [31:0]  mem_addr;
  logic         mem_rden;
  logic [127:0] mem_data;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;

  modport master (
    input  cpu_req, cpu_addr, inv, mem_data,
    output cpu_data, cpu_stall, mem_addr, mem_rden, hit_cnt, miss_cnt
  );

  modport slave (
    output cpu_req, cpu_addr, inv, mem_data,
    input  cpu_data, cpu_stall, mem_addr, mem_rden, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/icache_line_fetch.sv
// Direct-mapped instruction cache with a 3-state line-fill FSM (IDLE/FETCH/FILL).
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module icache_line_fetch #(
  parameter  int IDX_W = 6,
  localparam int TAG_W = 32 - 4 - IDX_W,
  localparam int LINES = 1 << IDX_W
) (
  input  logic               clk,
  input  logic               rst,
  icache_line_fetch_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FILL  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic               miss_start_s;
  logic               hit_s;

  logic [IDX_W-1:0]   idx_s;
  logic [TAG_W-1:0]   tag_s;
  logic [1:0]         off_s;
  logic [127:0]       line_s;
  logic [31:0]        word_s;

  logic [27:0]        miss_line_r;
  logic [IDX_W-1:0]   fill_idx_s;
  logic [TAG_W-1:0]   fill_tag_s;
  logic [31:0]        mem_addr_r;
  logic               mem_rden_r;

  logic [LINES-1:0]   valid_r;
  logic [TAG_W-1:0]   tag_r  [LINES];
  logic [127:0]       data_r [LINES];

  logic               unused_s;

  assign idx_s      = bus.cpu_addr[4+IDX_W-1:4];
  assign tag_s      = bus.cpu_addr[31:4+IDX_W];
  assign off_s      = bus.cpu_addr[3:2];
  assign fill_idx_s = miss_line_r[IDX_W-1:0];
  assign fill_tag_s = miss_line_r[27:IDX_W];
  assign unused_s   = ^bus.cpu_addr[1:0];

  assign line_s = data_r[idx_s];
  assign hit_s  = bus.cpu_req && valid_r[idx_s] && (tag_r[idx_s] == tag_s) && (state_r == IDLE);

  // Select the requested word out of the indexed line.
  always_comb begin
    word_s = 32'd0;
    case (off_s)
      2'd0:    word_s = line_s[31:0];
      2'd1:    word_s = line_s[63:32];
      2'd2:    word_s = line_s[95:64];
      2'd3:    word_s = line_s[127:96];
      default: word_s = 32'd0;
    endcase
  end

  assign bus.cpu_data  = word_s;
  assign bus.cpu_stall = (bus.cpu_req && !hit_s) || (state_r != IDLE);
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_rden  = mem_rden_r;

  // Next-state logic: a miss in IDLE launches a fixed FETCH -> FILL sequence.
  always_comb begin
    next_state_s = state_r;
    miss_start_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.cpu_req && !hit_s) begin
          next_state_s = FETCH;
          miss_start_s = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      FETCH:   next_state_s = FILL;
      FILL:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Miss address latch and memory request; mem_addr holds between requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_line_r <= 28'd0;
      mem_addr_r  <= 32'd0;
      mem_rden_r  <= 1'b0;
    end else begin
      mem_rden_r <= miss_start_s;
      if (miss_start_s) begin
        miss_line_r <= bus.cpu_addr[31:4];
        mem_addr_r  <= {bus.cpu_addr[31:4], 4'b0000};
      end
    end
  end

  // Valid bits: invalidate beats a coincident fill.
  always_ff @(posedge clk) begin
    if (rst || bus.inv) begin
      valid_r <= '0;
    end else if (state_r == FILL) begin
      valid_r[fill_idx_s] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; the returned line is only captured in FILL.
  always_ff @(posedge clk) begin
    if (state_r == FILL) begin
      data_r[fill_idx_s] <= bus.mem_data;
      tag_r[fill_idx_s]  <= fill_tag_s;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_r;
  logic [31:0] miss_cnt_r;

  // Saturating statistics counters; only reset clears them, not inv.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_r  <= 32'd0;
      miss_cnt_r <= 32'd0;
    end else begin
      if (hit_s && (hit_cnt_r != 32'hFFFF_FFFF)) begin
        hit_cnt_r <= hit_cnt_r + 32'd1;
      end
      if (miss_start_s && (miss_cnt_r != 32'hFFFF_FFFF)) begin
        miss_cnt_r <= miss_cnt_r + 32'd1;
      end
    end
  end

  assign bus.hit_cnt  = hit_cnt_r;
  assign bus.miss_cnt = miss_cnt_r;
`else
  assign bus.hit_cnt  = 32'd0;
  assign bus.miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_icache_line_fetch.sv
// Directed bench for icache_line_fetch with a one-cycle-latency line memory model.
module tb_icache_line_fetch;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  icache_line_fetch_if ifc ();

  icache_line_fetch #(.IDX_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h0000_0040: return 32'h1111_1111;
      32'h0000_0044: return 32'h2222_2222;
      32'h0000_0048: return 32'h3333_3333;
      32'h0000_004C: return 32'h4444_4444;
      32'h0000_0440: return 32'hDEAD_BEEF;
      default:       return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    return {word_at(a + 32'd12), word_at(a + 32'd8), word_at(a + 32'd4), word_at(a)};
  endfunction

  // Memory registers the line on the rden edge; outside that window it drives garbage.
  logic [127:0] mem_q;
  logic         mem_vld;
  always @(posedge clk) begin
    if (ifc.mem_rden) begin
      mem_q   <= line_of(ifc.mem_addr);
      mem_vld <= 1'b1;
    end else begin
      mem_vld <= 1'b0;
    end
  end
  assign ifc.mem_data = mem_vld ? mem_q : {4{32'hBAD0_BAD0}};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    total   = 0;
    passed  = 0;
    mem_vld = 1'b0;
    mem_q   = '0;
    rst          = 1'b1;
    ifc.cpu_req  = 1'b0;
    ifc.cpu_addr = 32'h0;
    ifc.inv      = 1'b0;
    tick();
    tick();

    // Reset state
    settle();
    chk("rst_rden", {31'd0, ifc.mem_rden}, 32'd0);
    chk("rst_addr", ifc.mem_addr, 32'h0);
    chk("rst_stall_noreq", {31'd0, ifc.cpu_stall}, 32'd0);
    chk("rst_hitcnt", ifc.hit_cnt, 32'd0);
    chk("rst_misscnt", ifc.miss_cnt, 32'd0);
    ifc.cpu_req = 1'b1;
    ifc.cpu_addr = 32'h48;
    settle();
    chk("rst_stall_req", {31'd0, ifc.cpu_stall}, 32'd1);
    tick();
    rst = 1'b0;

    // Cold miss at 0x48
    settle();
    chk("cold_stall_n", {31'd0, ifc.cpu_stall}, 32'd1);
    chk("cold_rden_n", {31'd0, ifc.mem_rden}, 32'd0);
    tick();
    chk("cold_fetch_rden", {31'd0, ifc.mem_rden}, 32'd1);
    chk("cold_fetch_addr", ifc.mem_addr, 32'h40);
    chk("cold_fetch_stall", {31'd0, ifc.cpu_stall}, 32'd1);
    tick();
    chk("cold_fill_rden", {31'd0, ifc.mem_rden}, 32'd0);
    chk("cold_fill_addr_hold", ifc.mem_addr, 32'h40);
    chk("cold_fill_stall", {31'd0, ifc.cpu_stall}, 32'd1);
    tick();
    chk("cold_hit_stall", {31'd0, ifc.cpu_stall}, 32'd0);
    chk("cold_hit_data", ifc.cpu_data, 32'h3333_3333);
    tick();

    // Same-line hits (5 hit edges in total including the one above)
    ifc.cpu_addr = 32'h4C; settle();
    chk("hit4c_stall", {31'd0, ifc.cpu_stall}, 32'd0);
    chk("hit4c_data", ifc.cpu_data, 32'h4444_4444);
    chk("hit4c_rden", {31'd0, ifc.mem_rden}, 32'd0);
    tick();
    ifc.cpu_addr = 32'h40; settle();
    chk("hit40_data", ifc.cpu_data, 32'h1111_1111);
    tick();
    ifc.cpu_addr = 32'h44; settle();
    chk("hit44_data", ifc.cpu_data, 32'h2222_2222);
    tick();
    ifc.cpu_addr = 32'h4C; settle();
    chk("hit4c_again_stall", {31'd0, ifc.cpu_stall}, 32'd0);
    tick();
    chk("hits_no_rden", {31'd0, ifc.mem_rden}, 32'd0);
    ifc.cpu_req = 1'b0; settle();
`ifdef ICACHE_STATS_EN
    chk("stats_hit", ifc.hit_cnt, 32'd5);
    chk("stats_miss", ifc.miss_cnt, 32'd1);
`else
    chk("stats_hit_off", ifc.hit_cnt, 32'd0);
    chk("stats_miss_off", ifc.miss_cnt, 32'd0);
`endif

    // Conflict miss 0x440 evicts 0x40
    ifc.cpu_req = 1'b1; ifc.cpu_addr = 32'h440; settle();
    chk("conf_stall", {31'd0, ifc.cpu_stall}, 32'd1);
    tick();
    chk("conf_fetch_addr", ifc.mem_addr, 32'h440);
    chk("conf_fetch_rden", {31'd0, ifc.mem_rden}, 32'd1);
    tick();
    tick();
    chk("conf_hit_stall", {31'd0, ifc.cpu_stall}, 32'd0);
    chk("conf_hit_data", ifc.cpu_data, 32'hDEAD_BEEF);
    ifc.cpu_addr = 32'h40; settle();
    chk("conf_back_miss", {31'd0, ifc.cpu_stall}, 32'd1);
    tick();
    chk("conf_back_addr", ifc.mem_addr, 32'h40);
    tick();
    tick();
    chk("conf_back_data", ifc.cpu_data, 32'h1111_1111);
    chk("conf_back_stall", {31'd0, ifc.cpu_stall}, 32'd0);

    // Invalidate during steady hits
    ifc.inv = 1'b1; settle();
    chk("inv_cycle_hit", {31'd0, ifc.cpu_stall}, 32'd0);
    tick();
    ifc.inv = 1'b0; settle();
    chk("inv_next_miss", {31'd0, ifc.cpu_stall}, 32'd1);
    tick();
    chk("inv_fetch_rden", {31'd0, ifc.mem_rden}, 32'd1);
    tick();
    // Invalidate coinciding with FILL wins
    ifc.inv = 1'b1; settle();
    tick();
    ifc.inv = 1'b0; settle();
    chk("invfill_stall", {31'd0, ifc.cpu_stall}, 32'd1);
    chk("invfill_idle_rden", {31'd0, ifc.mem_rden}, 32'd0);
    tick();
    chk("invfill_refetch", {31'd0, ifc.mem_rden}, 32'd1);
    tick();
    tick();
    chk("invfill_hit", {31'd0, ifc.cpu_stall}, 32'd0);

    // Reset during FETCH of 0x80
    ifc.cpu_addr = 32'h80; settle();
    tick();
    chk("rstf_fetch_addr", ifc.mem_addr, 32'h80);
    rst = 1'b1;
    tick();
    rst = 1'b0; ifc.cpu_addr = 32'h40; settle();
    chk("rstf_rden", {31'd0, ifc.mem_rden}, 32'd0);
    chk("rstf_addr", ifc.mem_addr, 32'h0);
    chk("rstf_40_miss", {31'd0, ifc.cpu_stall}, 32'd1);
    tick();
    tick();
    tick();
    chk("rstf_40_hit", ifc.cpu_data, 32'h1111_1111);

    // Request withdrawn during FETCH: line still installed
    ifc.cpu_addr = 32'hC4; settle();
    tick();
    ifc.cpu_req = 1'b0; settle();
    chk("wd_fetch_stall", {31'd0, ifc.cpu_stall}, 32'd1);
    tick();
    chk("wd_fill_stall", {31'd0, ifc.cpu_stall}, 32'd1);
    tick();
    chk("wd_idle_stall", {31'd0, ifc.cpu_stall}, 32'd0);
    tick();
    ifc.cpu_req = 1'b1; settle();
    chk("wd_hit_stall", {31'd0, ifc.cpu_stall}, 32'd0);
    chk("wd_hit_data", ifc.cpu_data, 32'hC0DE_00C4);
    tick();
    chk("wd_no_rden", {31'd0, ifc.mem_rden}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
